// File: rtl/odd_seq_pkg.sv
// rtl/odd_seq_pkg.sv - shared types, constants and step helpers for the odd-sequence controller
package odd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam logic [2:0] ODD_FIRST_UP = 3'o1;
  localparam logic [2:0] ODD_FIRST_DN = 3'o7;

  // 3-bit arithmetic gives the 7->1 and 1->7 wraps for free; an even value recovers to 1.
  function automatic logic [2:0] odd_next(input logic [2:0] q, input logic dir);
    logic [2:0] r_nxt;
    if (!q[0]) begin
      r_nxt = ODD_FIRST_UP;
    end else if (dir) begin
      r_nxt = q - 3'd2;
    end else begin
      r_nxt = q + 3'd2;
    end
    return r_nxt;
  endfunction

  function automatic logic odd_is_wrap(input logic [2:0] q, input logic dir);
    return dir ? (q == ODD_FIRST_UP) : (q == ODD_FIRST_DN);
  endfunction

endpackage

// File: rtl/odd_step_counter.sv
// rtl/odd_step_counter.sv - 3-bit odd-value step register with load, enable and wrap flag
module odd_step_counter
  import odd_seq_pkg::*;
#(
  parameter logic [2:0] SEED = 3'o1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [2:0] i_load_val,
  input  logic       i_en,
  input  logic       i_dir,
  output logic [2:0] o_q,
  output logic       o_wrap
);

  logic [2:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_q <= SEED;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_en) begin
      r_q <= odd_next(r_q, i_dir);
    end
  end

  assign o_q    = r_q;
  assign o_wrap = odd_is_wrap(r_q, i_dir);

endmodule

// File: rtl/odd_seq_ctrl.sv
// rtl/odd_seq_ctrl.sv - start/pause/stop sequencer running the odd step counter for N laps
module odd_seq_ctrl
  import odd_seq_pkg::*;
#(
  parameter int unsigned LAP_W = 4,
  parameter logic [2:0]  SEED  = 3'o1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_stop,
  input  logic             i_dir,
  input  logic [LAP_W-1:0] i_laps,
  output logic [2:0]       o_q,
  output logic [LAP_W-1:0] o_lap_cnt,
  output logic             o_busy,
  output logic             o_done
);

  seq_state_t       r_state;
  logic             r_dir;
  logic [LAP_W-1:0] r_laps;
  logic [LAP_W-1:0] r_lap_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_start;
  logic             w_load;
  logic [2:0]       w_load_val;
  logic             w_step;
  logic             w_wrap;
  logic             w_last;
  logic [LAP_W-1:0] w_lap_nxt;

  assign w_start    = (r_state == IDLE) && i_start && !i_stop;
  assign w_load     = w_start && (i_laps != '0);
  assign w_load_val = i_dir ? ODD_FIRST_DN : ODD_FIRST_UP;
  assign w_step     = !i_stop && !i_pause && ((r_state == RUN) || (r_state == HOLD));
  assign w_lap_nxt  = r_lap_cnt + LAP_W'(1);
  // Completion on equality means the lap counter can never pass the request.
  assign w_last     = w_step && w_wrap && (w_lap_nxt == r_laps);

  odd_step_counter #(
    .SEED(SEED)
  ) u_step_counter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_step),
    .i_dir      (r_dir),
    .o_q        (o_q),
    .o_wrap     (w_wrap)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_dir     <= 1'b0;
      r_laps    <= '0;
      r_lap_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_dir  <= i_dir;
            r_laps <= i_laps;
            if (i_laps == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= RUN;
              r_busy    <= 1'b1;
              r_lap_cnt <= '0;
            end
          end
        end
        RUN, HOLD: begin
          if (i_stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (i_pause) begin
            r_state <= HOLD;
          end else begin
            if (w_wrap) begin
              r_lap_cnt <= w_lap_nxt;
            end
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_lap_cnt = r_lap_cnt;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule
